// File: rtl/matrix_loader_if.sv
// Stream-in / matrix-out bundle between the matrix source, the loader and the inverter consumer.
// Handshakes: a word moves when in_valid && in_ready on a rising edge; mat_valid holds until mat_ack is sampled.
interface matrix_loader_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]    in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [25*WIDTH-1:0] a_flat;
  logic [25*WIDTH-1:0] b_flat;
  logic                mat_valid;
  logic                mat_ack;
  logic                pivot_zero;
  logic                frame_err;

  modport slave (
    input  in_data, in_valid, in_last, mat_ack,
    output in_ready, a_flat, b_flat, mat_valid, pivot_zero, frame_err
  );

  modport master (
    output in_data, in_valid, in_last, mat_ack,
    input  in_ready, a_flat, b_flat, mat_valid, pivot_zero, frame_err
  );
endinterface

// File: rtl/matrix_loader.sv
// Collects a 5x5 matrix row-major from a word stream, holds it (with identity B) for the
// combinational inverter, and presents mat_valid after a settle period until acknowledged.
module matrix_loader #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  matrix_loader_if.slave     bus,
  output logic [1:0]         dbg_state,
  output logic [4:0]         dbg_idx
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t              state;
  logic [4:0]          idx;
  logic [7:0]          cnt;
  logic [25*WIDTH-1:0] a_q;
  logic                in_ready_q;
  logic                mat_valid_q;
  logic                pivot_q;
  logic                ferr_q;
  logic                accept;

  // in_ready is only ever high in FILL, so accept implies FILL.
  assign accept = bus.in_valid && in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      idx         <= 5'd0;
      cnt         <= 8'd0;
      a_q         <= '0;
      in_ready_q  <= 1'b0;
      mat_valid_q <= 1'b0;
      pivot_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      case (state)
        FILL: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            a_q[WIDTH*int'(idx) +: WIDTH] <= bus.in_data;
            if (idx == 5'd24) begin
              idx <= 5'd0;
              if (bus.in_last) begin
                // Entry 0 was written at the start of this frame, so a_q already holds a00.
                pivot_q    <= (a_q[WIDTH-1:0] == '0);
                cnt        <= 8'(SETTLE_CYCLES);
                state      <= SETTLE;
                in_ready_q <= 1'b0;
              end else begin
                ferr_q <= 1'b1;
              end
            end else if (bus.in_last) begin
              idx    <= 5'd0;
              ferr_q <= 1'b1;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        SETTLE: begin
          if (cnt <= 8'd1) begin
            cnt         <= 8'd0;
            state       <= HOLD;
            mat_valid_q <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (bus.mat_ack) begin
            state       <= FILL;
            mat_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= FILL;
          mat_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < 25; i++) begin : g_ident
    assign bus.b_flat[WIDTH*i +: WIDTH] = ((i / 5) == (i % 5)) ? WIDTH'(1) : '0;
  end

  assign bus.a_flat     = a_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.mat_valid  = mat_valid_q;
  assign bus.pivot_zero = pivot_q;
  assign bus.frame_err  = ferr_q;
  assign dbg_state      = state;
  assign dbg_idx        = idx;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: a frame table plus hand sequences for HOLD wait and async reset.
module tb_matrix_loader;
  localparam int W = 32;
  localparam int S = 4;

  typedef struct {
    int          n;
    int          last_pos;
    logic [31:0] base;
    bit          zero_a00;
    bit          exp_err;
    bit          exp_pz;
    int          hold;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] dbg_state;
  logic [4:0] dbg_idx;

  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0]    exp_q[$];
  logic [25*W-1:0] exp_b;
  vec_t            vecs[8];

  always #5 clk = ~clk;

  matrix_loader_if #(.WIDTH(W)) bus ();

  matrix_loader #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_idx   (dbg_idx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [25*W-1:0] act, input logic [25*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_flat();
    for (int i = 0; i < 25; i++)
      check($sformatf("a_flat[%0d]", i), bus.a_flat[W*i +: W], exp_q[i]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " in_ready"}, bus.in_ready, 0);
    check({tag, " mat_valid"}, bus.mat_valid, 0);
    check({tag, " frame_err"}, bus.frame_err, 0);
    check({tag, " pivot_zero"}, bus.pivot_zero, 0);
    check({tag, " idx"}, dbg_idx, 0);
    check({tag, " state"}, dbg_state, 0);
    check_wide({tag, " a_flat"}, bus.a_flat, '0);
    check_wide({tag, " b_flat"}, bus.b_flat, exp_b);
  endtask

  task automatic send_frame(input int n, input int last_pos, input logic [31:0] base, input bit zero_a00);
    logic [31:0] w;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      w = (i == 0 && zero_a00) ? 32'd0 : base + 32'(i);
      check($sformatf("in_ready before word %0d", i), bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      bus.in_last  = (i + 1 == last_pos);
      exp_q.push_back(w);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic run_vec(input vec_t v);
    send_frame(v.n, v.last_pos, v.base, v.zero_a00);
    if (v.exp_err) begin
      check("frame_err pulse", bus.frame_err, 1);
      check("mat_valid after err", bus.mat_valid, 0);
      step();
      check("frame_err one cycle", bus.frame_err, 0);
      check("idx after err", dbg_idx, 0);
      check("mat_valid idle", bus.mat_valid, 0);
      check("in_ready after err", bus.in_ready, 1);
      check("pivot_zero kept", bus.pivot_zero, 32'(v.exp_pz));
    end else begin
      check("frame_err none", bus.frame_err, 0);
      check("in_ready low at E", bus.in_ready, 0);
      check("pivot_zero", bus.pivot_zero, 32'(v.exp_pz));
      for (int k = 1; k < S; k++) begin
        step();
        check($sformatf("mat_valid early E+%0d", k), bus.mat_valid, 0);
      end
      step();
      check("mat_valid at E+S", bus.mat_valid, 1);
      check("state HOLD", dbg_state, 2);
      check("pivot_zero in HOLD", bus.pivot_zero, 32'(v.exp_pz));
      check_a_flat();
      check_wide("b_flat", bus.b_flat, exp_b);
      for (int k = 0; k < v.hold; k++) begin
        step();
        check("hold mat_valid", bus.mat_valid, 1);
        check("hold in_ready", bus.in_ready, 0);
      end
      if (v.hold > 0) check_a_flat();
      bus.mat_ack = 1'b1;
      step();
      bus.mat_ack = 1'b0;
      check("mat_valid after ack", bus.mat_valid, 0);
      check("in_ready after ack", bus.in_ready, 1);
      check("pivot_zero after ack", bus.pivot_zero, 32'(v.exp_pz));
    end
  endtask

  initial begin
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        exp_b[W*(5*r+c) +: W] = (r == c) ? W'(1) : W'(0);

    vecs[0] = '{25, 25, 32'd1,   1'b0, 1'b0, 1'b0, 10};
    vecs[1] = '{25, 25, 32'd100, 1'b0, 1'b0, 1'b0, 0};
    vecs[2] = '{7,  7,  32'd50,  1'b0, 1'b1, 1'b0, 0};
    vecs[3] = '{25, 25, 32'd60,  1'b0, 1'b0, 1'b0, 0};
    vecs[4] = '{25, 0,  32'd70,  1'b0, 1'b1, 1'b0, 0};
    vecs[5] = '{25, 25, 32'd5,   1'b1, 1'b0, 1'b1, 2};
    vecs[6] = '{7,  7,  32'd80,  1'b0, 1'b1, 1'b1, 0};
    vecs[7] = '{25, 25, 32'd90,  1'b0, 1'b0, 1'b0, 0};

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    bus.mat_ack  = 1'b0;
    step();
    step();
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check("in_ready before first edge", bus.in_ready, 0);
    step();
    check("in_ready after reset", bus.in_ready, 1);

    // in_last without in_valid must be ignored; mat_ack outside HOLD too.
    bus.in_last = 1'b1;
    bus.mat_ack = 1'b1;
    step();
    bus.in_last = 1'b0;
    bus.mat_ack = 1'b0;
    check("stray in_last frame_err", bus.frame_err, 0);
    check("stray in_last idx", dbg_idx, 0);
    check("stray mat_ack state", dbg_state, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset at word 12.
    send_frame(12, 0, 32'd300, 1'b0);
    check("idx at word 12", dbg_idx, 12);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset mid-frame");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("in_ready after mid-frame reset", bus.in_ready, 1);
    run_vec(vecs[3]);

    // Reset during SETTLE, with pivot_zero set so its clearing is visible.
    send_frame(25, 25, 32'd400, 1'b1);
    step();
    check("state SETTLE", dbg_state, 1);
    check("pivot_zero in SETTLE", bus.pivot_zero, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset in settle");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("in_ready after settle reset", bus.in_ready, 1);
    run_vec(vecs[7]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
